// File: rtl/pdh_gpio_cmd_issuer.sv
// pdh_gpio_cmd_issuer: drives one command at a time onto the PDH GPIO word and
// returns the echoed callback payload, or the current callback payload on timeout.
module pdh_gpio_cmd_issuer #(
    parameter int CMD_BITS       = 4,
    parameter int DATA_BITS      = 26,
    parameter int SETUP_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [CMD_BITS-1:0]  req_cmd_i,
    input  logic [DATA_BITS-1:0] req_data_i,
    output logic [31:0]          gpio_o,
    input  logic [31:0]          gpio_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [27:0]          rsp_data_o,
    output logic                 rsp_timeout_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;
    localparam int CW = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + RELEASE_CYCLES + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   gpio_q, gpio_d;
    logic [27:0]   rsp_data_q, rsp_data_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          echo, done;

    assign echo = gpio_i[31:28] == gpio_q[29:26];
    assign done = (cnt_q >= CW'(SETTLE_CYCLES) && echo) || cnt_q == CW'(TIMEOUT_CYCLES);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        gpio_d        = gpio_q;
        gpio_d[31]    = core_rst_i;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_q && !core_rst_i) begin
                gpio_d[30:0] = {1'b0, req_cmd_i, req_data_i};
                cnt_d        = '0;
                state_d      = SETUP;
            end
            SETUP: if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                gpio_d[30] = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: if (done) begin
                rsp_data_d    = gpio_i[27:0];
                rsp_timeout_d = !echo;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                gpio_d[30]  = 1'b0;
                cnt_d       = '0;
                state_d     = RELEASE;
            end
            RELEASE: if (cnt_q == CW'(RELEASE_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Core reset aborts any transaction silently; no response is produced.
        if (core_rst_i && state_q != IDLE) begin
            state_d     = IDLE;
            gpio_d[30]  = 1'b0;
            rsp_valid_d = 1'b0;
        end
        req_ready_d = state_d == IDLE && !core_rst_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gpio_q        <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gpio_q        <= gpio_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign gpio_o        = gpio_q;
    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_timeout_q;
endmodule

// File: doc/pdh_gpio_cmd_issuer.md
# pdh_gpio_cmd_issuer

Fabric-side initiator for the PDH core's 32-bit GPIO command channel. It accepts one command at a time on a ready/valid request port and packs it into the command word with the strobe low. It raises the strobe, waits for the core's callback word to echo the command, and returns the callback payload on a ready/valid response port. It sits where the PS would otherwise drive the channel: in hardware sequencers, and as the stimulus master in core-level benches.

## Interface
Parameters:
- CMD_BITS, 4, command field width
- DATA_BITS, 26, data field width
- SETUP_CYCLES, 2, cycles cmd/data are held with strobe low before strobe rises (≥1)
- SETTLE_CYCLES, 4, cycles after strobe rise before the first callback sample (≥1)
- TIMEOUT_CYCLES, 1024, cycles after strobe rise with no echo before giving up (> SETTLE_CYCLES)
- RELEASE_CYCLES, 2, cycles strobe is held low after a response before the next request is accepted (≥1)

Ports:
- clk  in  1  fabric clock, 125 MHz
- rst  in  1  synchronous, active-high reset
- core_rst_i  in  1  request core reset; drives command word bit 31
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_cmd_i  in  CMD_BITS  command code
- req_data_i  in  DATA_BITS  command data
- gpio_o  out  32  command word to core: [31] core reset, [30] strobe, [29:26] cmd, [25:0] data
- gpio_i  in  32  callback word from core: [31:28] cmd echo, [27:0] payload
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  28  captured callback payload
- rsp_timeout_o  out  1  response produced by timeout, not by echo

## Operation
- All outputs are registered. Reset values: gpio_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0. The FSM resets to IDLE.
- gpio_o[31] is a registered copy of core_rst_i.
- FSM states and behaviour:
  - IDLE: req_ready_o=1 unless core_rst_i=1. On req_valid_i & req_ready_o, latch cmd/data into gpio_o[29:0] with strobe=0, clear the counter, then go to SETUP.
  - SETUP: strobe=0 for SETUP_CYCLES cycles, then set strobe=1 and go to WAIT.
  - WAIT: strobe=1; the counter counts from the strobe-rise cycle.
    - From count SETTLE_CYCLES on, sample gpio_i every cycle.
    - On the first cycle with gpio_i[31:28]==cmd, capture gpio_i[27:0] into rsp_data_o, set rsp_timeout_o=0, then go to RESP.
    - If the count reaches TIMEOUT_CYCLES first, capture gpio_i[27:0], set rsp_timeout_o=1, then go to RESP.
  - RESP: rsp_valid_o=1 and strobe stays high. rsp_data_o and rsp_timeout_o stay stable until rsp_ready_i. On the handshake, drop rsp_valid_o and strobe, then go to RELEASE.
  - RELEASE: strobe=0 for RELEASE_CYCLES cycles, then go to IDLE.
- gpio_o[29:0] holds the last command after the transaction, so the callback stays meaningful while idle.
- Command 0 (idle) echoes 0 and completes normally.
- Only one transaction is outstanding at a time. req_ready_o=0 in every state except IDLE.
- When core_rst_i is asserted in any state other than IDLE:
  - abort and go to IDLE with strobe=0 and rsp_valid_o=0;
  - no response is issued;
  - req_ready_o stays 0 while core_rst_i=1.
- rst is asserted mid-transaction: all registers return to reset values on the next edge. No partial response is issued.
- core_rst_i and req_valid_i asserted in the same cycle: the request is not accepted.

## Timing
- Request accepted at edge A:
  - gpio_o shows cmd/data with strobe=0 from A+1;
  - strobe=1 from A+1+SETUP_CYCLES, denoted S;
  - first callback sample at S+SETTLE_CYCLES.
- Echo present at the first sample: rsp_valid_o rises at S+SETTLE_CYCLES+1, i.e. A+8 with default parameters.
- Timeout: rsp_valid_o rises at S+TIMEOUT_CYCLES+1.
- Response handshake at edge R: strobe=0 from R+1. req_ready_o rises at R+1+RELEASE_CYCLES.
- Strobe is never high for fewer than SETTLE_CYCLES+1 cycles and never low for fewer than RELEASE_CYCLES cycles between commands. This guarantees a clean rising edge at the core for every command.

## Test plan
- LED command (cmd=1, data=0xA5) against a core model: strobe rises at A+3 → rsp_valid_o at A+8, rsp_data_o=0x00000A5, rsp_timeout_o=0. The core's LED register reads 0xA5.
- DAC command (cmd=2, data={bit14=1, 0x3FFF}) → rsp_data_o[27:14]=0x3FFF, rsp_data_o[13:0]=0x2000. gpio_o[30] sees exactly one rising edge.
- Responder model stuck echoing 0 with cmd=1 → rsp_timeout_o=1 at S+1025. The FSM returns to IDLE after the handshake and RELEASE.
- rsp_ready_i held low 10 cycles → rsp_valid_o, rsp_data_o and strobe stay constant. Strobe falls the cycle after rsp_ready_i=1.
- rst pulsed mid-WAIT → gpio_o=0 and rsp_valid_o=0 next cycle; no response. The next request completes normally.
- core_rst_i asserted during SETUP, and also in the same cycle as req_valid_i → gpio_o[31]=1, no response, req_ready_o=0. Operation resumes after release.
